// File: rtl/wb_timer_slave.sv
// Wishbone classic-cycle timer/compare peripheral with programmable ack wait states.
// Optional prescaler on offset 4 is built only when WB_TIMER_PRESCALE_EN is defined.
module wb_timer_slave #(
  parameter int unsigned WAIT_STATES   = 0,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [2:0]  wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  wait_cnt;

  logic [2:0]  ctrl;
  logic [31:0] count;
  logic [31:0] compare;
  logic        match;

  logic        req;
  logic        commit;
  logic        tick;
  logic        hit;
  logic [31:0] rd_data;

  logic        en;
  logic        autoreload;
  logic        ie;

  assign en         = ctrl[0];
  assign autoreload = ctrl[1];
  assign ie         = ctrl[2];

  assign req    = wb_cyc_i & wb_stb_i;
  assign commit = (state == S_ACK) & req & wb_we_i;
  assign hit    = tick & (count == compare);
  assign irq_o  = match & ie;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

`ifdef WB_TIMER_PRESCALE_EN
  logic [15:0] prescale;
  logic [15:0] psc_cnt;
  logic [31:0] psc_merged;

  assign psc_merged = lane_merge({16'd0, prescale}, wb_dat_i, wb_sel_i);
  assign tick       = en & (psc_cnt == prescale);

  // Writing PRESCALE restarts the divider so the new period starts cleanly.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prescale <= 16'd0;
      psc_cnt  <= 16'd0;
    end else if (commit && (wb_adr_i == 3'd4)) begin
      prescale <= psc_merged[15:0];
      psc_cnt  <= 16'd0;
    end else if (en) begin
      psc_cnt <= (psc_cnt == prescale) ? 16'd0 : psc_cnt + 16'd1;
    end
  end
`else
  assign tick = en;
`endif

  always_comb begin
    rd_data = 32'd0;
    case (wb_adr_i)
      3'd0: rd_data = {29'd0, ctrl};
      3'd1: rd_data = count;
      3'd2: rd_data = compare;
      3'd3: rd_data = {31'd0, match};
`ifdef WB_TIMER_PRESCALE_EN
      3'd4: rd_data = {16'd0, prescale};
`endif
      default: rd_data = 32'd0;
    endcase
  end

  // Read data is captured on the edge that enters ACK and is zero otherwise.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'd0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'd0;
      case (state)
        S_IDLE: begin
          if (req) begin
            if (WAIT_STATES > 0) begin
              state    <= S_WAIT;
              wait_cnt <= WS_LOAD;
            end else begin
              state    <= S_ACK;
              wb_ack_o <= 1'b1;
              wb_dat_o <= rd_data;
            end
          end
        end
        S_WAIT: begin
          if (!req) begin
            state <= S_IDLE;
          end else if (wait_cnt == 4'd0) begin
            state    <= S_ACK;
            wb_ack_o <= 1'b1;
            wb_dat_o <= rd_data;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ACK: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // A bus write to COUNT wins over the tick; a match set wins over a W1C.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ctrl    <= 3'd0;
      count   <= 32'd0;
      compare <= RESET_COMPARE;
      match   <= 1'b0;
    end else begin
      if (commit && (wb_adr_i == 3'd0) && wb_sel_i[0]) begin
        ctrl <= wb_dat_i[2:0];
      end

      if (commit && (wb_adr_i == 3'd1)) begin
        count <= lane_merge(count, wb_dat_i, wb_sel_i);
      end else if (tick) begin
        count <= (hit && autoreload) ? 32'd0 : count + 32'd1;
      end

      if (commit && (wb_adr_i == 3'd2)) begin
        compare <= lane_merge(compare, wb_dat_i, wb_sel_i);
      end

      if (hit) begin
        match <= 1'b1;
      end else if (commit && (wb_adr_i == 3'd3) && wb_sel_i[0] && wb_dat_i[0]) begin
        match <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_timer_slave.sv
// Self-checking bench for wb_timer_slave: directed vector table, corner sequences and
// random bus traffic against a cycle-level register model of the timer.
module tb_wb_timer_slave;

  localparam int unsigned WS      = 2;
  localparam logic [31:0] RST_CMP = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i  = 1'b0;
  logic [2:0]  wb_adr_i = 3'd0;
  logic [3:0]  wb_sel_i = 4'd0;
  logic [31:0] wb_dat_i = 32'd0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        irq_o;

  int errors = 0;
  int checks = 0;

  wb_timer_slave #(
    .WAIT_STATES  (WS),
    .RESET_COMPARE(RST_CMP)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_we_i (wb_we_i),
    .wb_adr_i(wb_adr_i),
    .wb_sel_i(wb_sel_i),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o),
    .irq_o   (irq_o)
  );

  always #5 clk = ~clk;

  // Register model of the peripheral
  logic [2:0]  m_ctrl;
  logic [31:0] m_count;
  logic [31:0] m_compare;
  logic        m_match;
`ifdef WB_TIMER_PRESCALE_EN
  logic [15:0] m_psc;
  logic [15:0] m_psc_cnt;
`endif

  typedef struct {
    logic        we;
    logic [2:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_ctrl    = 3'd0;
    m_count   = 32'd0;
    m_compare = RST_CMP;
    m_match   = 1'b0;
`ifdef WB_TIMER_PRESCALE_EN
    m_psc     = 16'd0;
    m_psc_cnt = 16'd0;
`endif
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {29'd0, m_ctrl};
      3'd1: return m_count;
      3'd2: return m_compare;
      3'd3: return {31'd0, m_match};
`ifdef WB_TIMER_PRESCALE_EN
      3'd4: return {16'd0, m_psc};
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock using the bus inputs of the current cycle.
  task automatic model_advance(input logic commit);
    logic        tick;
    logic        hit;
    logic [31:0] n_count;
    logic        n_match;
    logic [31:0] tmp;
`ifdef WB_TIMER_PRESCALE_EN
    tick = m_ctrl[0] && (m_psc_cnt == m_psc);
`else
    tick = m_ctrl[0];
`endif
    hit = tick && (m_count == m_compare);
    if (!tick) n_count = m_count;
    else if (hit && m_ctrl[1]) n_count = 32'd0;
    else n_count = m_count + 32'd1;
    n_match = m_match;
`ifdef WB_TIMER_PRESCALE_EN
    if (commit && wb_adr_i == 3'd4) begin
      tmp       = merge({16'd0, m_psc}, wb_dat_i, wb_sel_i);
      m_psc     = tmp[15:0];
      m_psc_cnt = 16'd0;
    end else if (m_ctrl[0]) begin
      m_psc_cnt = (m_psc_cnt == m_psc) ? 16'd0 : m_psc_cnt + 16'd1;
    end
`endif
    if (commit) begin
      case (wb_adr_i)
        3'd1: n_count = merge(m_count, wb_dat_i, wb_sel_i);
        3'd2: m_compare = merge(m_compare, wb_dat_i, wb_sel_i);
        3'd3: if (wb_sel_i[0] && wb_dat_i[0]) n_match = 1'b0;
        default: tmp = 32'd0;
      endcase
    end
    if (hit) n_match = 1'b1;
    if (commit && wb_adr_i == 3'd0 && wb_sel_i[0]) m_ctrl = wb_dat_i[2:0];
    m_count = n_count;
    m_match = n_match;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model step, then sample outputs on the following falling edge.
  task automatic step(input logic commit, input logic exp_ack, input logic [31:0] exp_dat);
    model_advance(commit);
    @(posedge clk);
    @(negedge clk);
    check_output("ack", {31'd0, wb_ack_o}, {31'd0, exp_ack});
    check_output("dat_o", wb_dat_o, exp_ack ? exp_dat : 32'd0);
    check_output("irq", {31'd0, irq_o}, {31'd0, m_match & m_ctrl[2]});
  endtask

  task automatic apply_stimulus(input logic we, input logic [2:0] adr, input logic [3:0] sel,
                                input logic [31:0] dat, output logic [31:0] rdata);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_sel_i = sel;
    wb_dat_i = dat;
    for (int k = 0; k < int'(WS); k++) step(1'b0, 1'b0, 32'd0);
    rdata = model_read(adr);
    step(1'b0, 1'b1, rdata);
    step(we, 1'b0, 32'd0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic bus_abort(input logic [2:0] adr, input logic [31:0] dat, input int n);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_adr_i = adr;
    wb_sel_i = 4'hF;
    wb_dat_i = dat;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'd0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        we;
    logic [2:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;

    vecs[0]  = '{1'b0, 3'd2, 4'hF, 32'h0,         1'b1, 32'hFFFF_FFFF};
    vecs[1]  = '{1'b0, 3'd7, 4'hF, 32'h0,         1'b1, 32'h0};
    vecs[2]  = '{1'b0, 3'd0, 4'hF, 32'h0,         1'b1, 32'h0};
    vecs[3]  = '{1'b0, 3'd3, 4'hF, 32'h0,         1'b1, 32'h0};
    vecs[4]  = '{1'b1, 3'd2, 4'b0010, 32'h1234_5678, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 3'd2, 4'hF, 32'h0,         1'b1, 32'hFFFF_56FF};
    vecs[6]  = '{1'b1, 3'd5, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 3'd5, 4'hF, 32'h0,         1'b1, 32'h0};
    vecs[8]  = '{1'b1, 3'd4, 4'hF, 32'h3,         1'b0, 32'h0};
`ifdef WB_TIMER_PRESCALE_EN
    vecs[9]  = '{1'b0, 3'd4, 4'hF, 32'h0,         1'b1, 32'h3};
`else
    vecs[9]  = '{1'b0, 3'd4, 4'hF, 32'h0,         1'b1, 32'h0};
`endif
    vecs[10] = '{1'b1, 3'd4, 4'hF, 32'h0,         1'b0, 32'h0};
    vecs[11] = '{1'b0, 3'd1, 4'hF, 32'h0,         1'b1, 32'h0};

    model_reset();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    check_output("reset_ack", {31'd0, wb_ack_o}, 32'd0);
    check_output("reset_dat", wb_dat_o, 32'd0);
    check_output("reset_irq", {31'd0, irq_o}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, rd);
      if (vecs[i].chk) check_output($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end

    // Aborted write to COUNT leaves it untouched; the next transfer still acks.
    bus_abort(3'd1, 32'h55, 1);
    apply_stimulus(1'b0, 3'd1, 4'hF, 32'd0, rd);
    check_output("abort_count", rd, 32'h0);

    // Autoreload with COMPARE=4, then W1C away from and coinciding with a match.
    apply_stimulus(1'b1, 3'd2, 4'hF, 32'd4, rd);
    apply_stimulus(1'b1, 3'd3, 4'hF, 32'd1, rd);
    apply_stimulus(1'b1, 3'd0, 4'h1, 32'd7, rd);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 32'd0);
      check_output("ar_irq_low", {31'd0, irq_o}, 32'd0);
    end
    step(1'b0, 1'b0, 32'd0);
    check_output("ar_irq_rise", {31'd0, irq_o}, 32'd1);
    apply_stimulus(1'b0, 3'd1, 4'hF, 32'd0, rd);
    check_output("ar_count", rd, 32'd2);
    apply_stimulus(1'b1, 3'd3, 4'h1, 32'd1, rd);
    check_output("w1c_clear", {31'd0, irq_o}, 32'd0);
    idle(3);
    apply_stimulus(1'b1, 3'd3, 4'h1, 32'd1, rd);
    check_output("w1c_vs_set", {31'd0, irq_o}, 32'd1);

    // Wrap through 32'hFFFF_FFFF with COMPARE=0.
    apply_stimulus(1'b1, 3'd0, 4'h1, 32'd0, rd);
    apply_stimulus(1'b1, 3'd1, 4'hF, 32'hFFFF_FFFE, rd);
    apply_stimulus(1'b1, 3'd2, 4'hF, 32'd0, rd);
    apply_stimulus(1'b1, 3'd3, 4'h1, 32'd1, rd);
    apply_stimulus(1'b1, 3'd0, 4'h1, 32'd5, rd);
    step(1'b0, 1'b0, 32'd0);
    check_output("wrap_irq0", {31'd0, irq_o}, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    check_output("wrap_irq1", {31'd0, irq_o}, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    check_output("wrap_irq2", {31'd0, irq_o}, 32'd1);
    apply_stimulus(1'b0, 3'd1, 4'hF, 32'd0, rd);
    check_output("wrap_count", rd, 32'd3);

`ifdef WB_TIMER_PRESCALE_EN
    apply_stimulus(1'b1, 3'd0, 4'h1, 32'd0, rd);
    apply_stimulus(1'b1, 3'd4, 4'hF, 32'd3, rd);
    apply_stimulus(1'b1, 3'd1, 4'hF, 32'd0, rd);
    apply_stimulus(1'b1, 3'd0, 4'h1, 32'd1, rd);
    idle(8);
    apply_stimulus(1'b0, 3'd1, 4'hF, 32'd0, rd);
    check_output("psc_count", rd, 32'd2);
    apply_stimulus(1'b1, 3'd4, 4'hF, 32'd0, rd);
`endif

    // Random traffic against the model.
    apply_stimulus(1'b1, 3'd1, 4'hF, 32'd0, rd);
    apply_stimulus(1'b1, 3'd2, 4'hF, 32'd6, rd);
    apply_stimulus(1'b1, 3'd0, 4'h1, 32'd7, rd);
    for (int i = 0; i < 80; i++) begin
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) begin
        bus_abort(3'($urandom_range(0, 7)), $urandom, $urandom_range(1, WS));
      end else begin
        we  = 1'($urandom_range(0, 1));
        adr = 3'($urandom_range(0, 7));
        sel = 4'($urandom);
        dat = $urandom_range(0, 1) ? 32'($urandom_range(0, 12)) : $urandom;
        if (adr == 3'd1) sel = 4'hF;
        apply_stimulus(we, adr, sel, dat, rd);
      end
    end

    // Reset in the middle of a write: no ack, write lost.
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_adr_i = 3'd2;
    wb_sel_i = 4'hF;
    wb_dat_i = 32'h77;
    step(1'b0, 1'b0, 32'd0);
    clr = 1'b1;
    #1;
    check_output("clr_ack", {31'd0, wb_ack_o}, 32'd0);
    model_reset();
    @(negedge clk);
    check_output("clr_ack_held", {31'd0, wb_ack_o}, 32'd0);
    check_output("clr_irq", {31'd0, irq_o}, 32'd0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    clr      = 1'b0;
    apply_stimulus(1'b0, 3'd2, 4'hF, 32'd0, rd);
    check_output("clr_compare", rd, RST_CMP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
